// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control FSM (FETCH/DECODE/EXEC/MEM/WB) with ready-handshake stalls.
// Define MULTICYCLE_CTRL_ILLEGAL_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [10:0]      opcode,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg2loc,
  output logic             alusrc,
  output logic             mem2reg,
  output logic             regwrite,
  output logic             memread,
  output logic             memwrite,
  output logic [3:0]       aluop,
  output logic [2:0]       signop,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [3:0] C_AND  = 4'd0;
  localparam logic [3:0] C_ORR  = 4'd1;
  localparam logic [3:0] C_ADD  = 4'd2;
  localparam logic [3:0] C_SUB  = 4'd3;
  localparam logic [3:0] C_ADDI = 4'd4;
  localparam logic [3:0] C_SUBI = 4'd5;
  localparam logic [3:0] C_B    = 4'd6;
  localparam logic [3:0] C_CBZ  = 4'd7;
  localparam logic [3:0] C_LDUR = 4'd8;
  localparam logic [3:0] C_STUR = 4'd9;
  localparam logic [3:0] C_MOVZ = 4'd10;
  localparam logic [3:0] C_ILL  = 4'd11;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire_s;
  logic [3:0]       cls_s;
  logic             dec_reg2loc_s, ex_alusrc_s;
  logic [2:0]       dec_signop_s;
  logic [3:0]       ex_aluop_s;

  // casez takes the first matching arm, which encodes the class priority order
  always_comb begin
    cls_s = C_ILL;
    casez (opcode)
      11'b10001010000: cls_s = C_AND;
      11'b10101010000: cls_s = C_ORR;
      11'b10001011000: cls_s = C_ADD;
      11'b11001011000: cls_s = C_SUB;
      11'b1001000100?: cls_s = C_ADDI;
      11'b1101000100?: cls_s = C_SUBI;
      11'b000101?????: cls_s = C_B;
      11'b10110100???: cls_s = C_CBZ;
      11'b11111000010: cls_s = C_LDUR;
      11'b11111000000: cls_s = C_STUR;
      11'b110100101??: cls_s = C_MOVZ;
      default:         cls_s = C_ILL;
    endcase
  end

  always_comb begin
    dec_reg2loc_s = (cls_s == C_CBZ) || (cls_s == C_STUR) || (cls_s == C_MOVZ);
    ex_alusrc_s   = (cls_s == C_ADDI) || (cls_s == C_SUBI) || (cls_s == C_LDUR) ||
                    (cls_s == C_STUR) || (cls_s == C_MOVZ);
    dec_signop_s  = 3'b000;
    ex_aluop_s    = 4'b0000;
    case (cls_s)
      C_AND:          ex_aluop_s = 4'b0000;
      C_ORR:          ex_aluop_s = 4'b0001;
      C_ADD:          ex_aluop_s = 4'b0010;
      C_SUB:          ex_aluop_s = 4'b0110;
      C_ADDI:         ex_aluop_s = 4'b0010;
      C_SUBI:         ex_aluop_s = 4'b0110;
      C_LDUR, C_STUR: begin dec_signop_s = 3'b001; ex_aluop_s = 4'b0010; end
      C_B:            begin dec_signop_s = 3'b010; ex_aluop_s = 4'b0111; end
      C_CBZ:          begin dec_signop_s = 3'b011; ex_aluop_s = 4'b0111; end
      C_MOVZ:         begin dec_signop_s = {1'b1, opcode[1:0]}; ex_aluop_s = 4'b0111; end
      default:        begin dec_signop_s = 3'b000; ex_aluop_s = 4'b0000; end
    endcase
  end

  // Per-state controls and next state; Reset overrides every output to 0
  always_comb begin
    state_d  = state_q;
    retire_s = 1'b0;
    imem_req = 1'b0; ir_write = 1'b0; pc_write = 1'b0; pc_src  = 1'b0;
    reg2loc  = 1'b0; alusrc   = 1'b0; mem2reg  = 1'b0; regwrite = 1'b0;
    memread  = 1'b0; memwrite = 1'b0; aluop    = 4'b0000; signop = 3'b000;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          state_d  = S_FETCH;
        end
      end
      S_DECODE: begin
        reg2loc = dec_reg2loc_s;
        signop  = dec_signop_s;
        if (cls_s == C_ILL) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_WB;
`endif
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        reg2loc = dec_reg2loc_s;
        signop  = dec_signop_s;
        alusrc  = ex_alusrc_s;
        aluop   = ex_aluop_s;
        case (cls_s)
          C_B:            begin pc_write = 1'b1; pc_src = 1'b1; state_d = S_FETCH; retire_s = 1'b1; end
          C_CBZ:          begin pc_write = 1'b1; pc_src = zero; state_d = S_FETCH; retire_s = 1'b1; end
          C_LDUR, C_STUR: state_d = S_MEM;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: begin
        reg2loc = dec_reg2loc_s;
        signop  = dec_signop_s;
        alusrc  = ex_alusrc_s;
        aluop   = ex_aluop_s;
        if (cls_s == C_LDUR) begin
          memread = 1'b1;
          state_d = dmem_ready ? S_WB : S_MEM;
        end else if (cls_s == C_STUR) begin
          memwrite = 1'b1;
          if (dmem_ready) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
            retire_s = 1'b1;
          end else begin
            state_d  = S_MEM;
          end
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        regwrite = (cls_s != C_ILL);
        mem2reg  = (cls_s == C_LDUR);
        pc_write = 1'b1;
        state_d  = S_FETCH;
        retire_s = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (Reset) begin
      imem_req = 1'b0; ir_write = 1'b0; pc_write = 1'b0; pc_src  = 1'b0;
      reg2loc  = 1'b0; alusrc   = 1'b0; mem2reg  = 1'b0; regwrite = 1'b0;
      memread  = 1'b0; memwrite = 1'b0; aluop    = 4'b0000; signop = 3'b000;
    end else begin
      retire_s = retire_s;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= S_FETCH;
      retired_q <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      if (retire_s) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      else          retired_q <= retired_q;
    end
  end

  assign state   = Reset ? S_FETCH : state_q;
  assign retired = Reset ? {CNT_W{1'b0}} : retired_q;

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  // Sticky flag set on the edge that enters TRAP
  always_ff @(posedge CLK) begin
    if (Reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_q | (state_d == S_TRAP);
  end

  assign illegal = Reset ? 1'b0 : illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control: per-cycle state/control tables per instruction.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        Reset, zero, imem_ready, dmem_ready;
  logic [10:0] opcode;
  logic        imem_req, ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg, regwrite, memread, memwrite;
  logic [3:0]  aluop;
  logic [2:0]  signop, state;
  logic [31:0] retired;
  logic        illegal;
  logic [16:0] ctl;

  int vecs = 0;
  int errs = 0;
  int exp_ret = 0;

  multicycle_control #(.CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .opcode(opcode), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg2loc(reg2loc), .alusrc(alusrc), .mem2reg(mem2reg), .regwrite(regwrite),
    .memread(memread), .memwrite(memwrite), .aluop(aluop), .signop(signop),
    .state(state), .retired(retired), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  assign ctl = {imem_req, ir_write, pc_write, pc_src, reg2loc, alusrc, mem2reg,
                regwrite, memread, memwrite, aluop, signop};

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    Reset = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b1; opcode = 11'b10001011000;
    tick();
    #1;
    if ({state, ctl, retired, illegal} !== 53'd0) begin
      errs++; $display("FAIL reset_hold: got st=%0d ctl=%b ret=%0d ill=%b, want all 0", state, ctl, retired, illegal);
    end
    vecs++;
    Reset = 1'b0;
    #1;
    if ({state, ctl, retired} !== {3'd0, 17'b1100000000_0000_000, 32'd0}) begin
      errs++; $display("FAIL reset_release: got st=%0d ctl=%b ret=%0d, want st=0 ctl=11000000000000000 ret=0", state, ctl, retired);
    end
    vecs++;
    exp_ret = 0;
  endtask

  task automatic test_addreg();
    logic [22:0] v [4] = '{
      {3'b110, 3'd0, 17'b1100000000_0000_000},
      {3'b110, 3'd1, 17'b0000000000_0000_000},
      {3'b110, 3'd2, 17'b0000000000_0010_000},
      {3'b110, 3'd4, 17'b0010000100_0000_000}};
    opcode = 11'b10001011000;
    for (int i = 0; i < 4; i++) begin
      {imem_ready, dmem_ready, zero} = v[i][22:20];
      #1;
      if ({state, ctl} !== v[i][19:0]) begin
        errs++; $display("FAIL addreg[%0d]: got st=%0d ctl=%b, want st=%0d ctl=%b", i, state, ctl, v[i][19:17], v[i][16:0]);
      end
      vecs++;
      tick();
    end
    exp_ret++;
    if (retired !== exp_ret) begin
      errs++; $display("FAIL addreg_retired: got %0d, want %0d", retired, exp_ret);
    end
    vecs++;
  endtask

  task automatic test_ldur();
    logic [22:0] v [8] = '{
      {3'b100, 3'd0, 17'b1100000000_0000_000},
      {3'b010, 3'd1, 17'b0000000000_0000_001},
      {3'b010, 3'd2, 17'b0000010000_0010_001},
      {3'b100, 3'd3, 17'b0000010010_0010_001},
      {3'b100, 3'd3, 17'b0000010010_0010_001},
      {3'b000, 3'd3, 17'b0000010010_0010_001},
      {3'b010, 3'd3, 17'b0000010010_0010_001},
      {3'b000, 3'd4, 17'b0010001100_0000_000}};
    opcode = 11'b11111000010;
    for (int i = 0; i < 8; i++) begin
      {imem_ready, dmem_ready, zero} = v[i][22:20];
      #1;
      if ({state, ctl} !== v[i][19:0]) begin
        errs++; $display("FAIL ldur[%0d]: got st=%0d ctl=%b, want st=%0d ctl=%b", i, state, ctl, v[i][19:17], v[i][16:0]);
      end
      vecs++;
      tick();
    end
    exp_ret++;
    if (retired !== exp_ret) begin
      errs++; $display("FAIL ldur_retired: got %0d, want %0d", retired, exp_ret);
    end
    vecs++;
  endtask

  task automatic test_cbz();
    logic [22:0] v [6] = '{
      {3'b111, 3'd0, 17'b1100000000_0000_000},
      {3'b111, 3'd1, 17'b0000100000_0000_011},
      {3'b111, 3'd2, 17'b0011100000_0111_011},
      {3'b110, 3'd0, 17'b1100000000_0000_000},
      {3'b111, 3'd1, 17'b0000100000_0000_011},
      {3'b110, 3'd2, 17'b0010100000_0111_011}};
    opcode = 11'b10110100101;
    for (int i = 0; i < 6; i++) begin
      {imem_ready, dmem_ready, zero} = v[i][22:20];
      #1;
      if ({state, ctl} !== v[i][19:0]) begin
        errs++; $display("FAIL cbz[%0d]: got st=%0d ctl=%b, want st=%0d ctl=%b", i, state, ctl, v[i][19:17], v[i][16:0]);
      end
      vecs++;
      tick();
    end
    exp_ret += 2;
    if (retired !== exp_ret) begin
      errs++; $display("FAIL cbz_retired: got %0d, want %0d", retired, exp_ret);
    end
    vecs++;
  endtask

  task automatic test_stur();
    logic [22:0] v [6] = '{
      {3'b010, 3'd0, 17'b1000000000_0000_000},
      {3'b010, 3'd0, 17'b1000000000_0000_000},
      {3'b110, 3'd0, 17'b1100000000_0000_000},
      {3'b010, 3'd1, 17'b0000100000_0000_001},
      {3'b010, 3'd2, 17'b0000110000_0010_001},
      {3'b010, 3'd3, 17'b0010110001_0010_001}};
    opcode = 11'b11111000000;
    for (int i = 0; i < 6; i++) begin
      {imem_ready, dmem_ready, zero} = v[i][22:20];
      #1;
      if ({state, ctl} !== v[i][19:0]) begin
        errs++; $display("FAIL stur[%0d]: got st=%0d ctl=%b, want st=%0d ctl=%b", i, state, ctl, v[i][19:17], v[i][16:0]);
      end
      vecs++;
      tick();
    end
    exp_ret++;
    if (retired !== exp_ret) begin
      errs++; $display("FAIL stur_retired: got %0d, want %0d", retired, exp_ret);
    end
    vecs++;
  endtask

  task automatic test_movz();
    logic [22:0] v [4] = '{
      {3'b100, 3'd0, 17'b1100000000_0000_000},
      {3'b100, 3'd1, 17'b0000100000_0000_101},
      {3'b100, 3'd2, 17'b0000110000_0111_101},
      {3'b100, 3'd4, 17'b0010000100_0000_000}};
    opcode = 11'b11010010101;
    for (int i = 0; i < 4; i++) begin
      {imem_ready, dmem_ready, zero} = v[i][22:20];
      #1;
      if ({state, ctl} !== v[i][19:0]) begin
        errs++; $display("FAIL movz[%0d]: got st=%0d ctl=%b, want st=%0d ctl=%b", i, state, ctl, v[i][19:17], v[i][16:0]);
      end
      vecs++;
      tick();
    end
    exp_ret++;
    if (retired !== exp_ret) begin
      errs++; $display("FAIL movz_retired: got %0d, want %0d", retired, exp_ret);
    end
    vecs++;
  endtask

`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  task automatic test_illegal();
    logic [22:0] v [5] = '{
      {3'b110, 3'd0, 17'b1100000000_0000_000},
      {3'b110, 3'd1, 17'b0000000000_0000_000},
      {3'b111, 3'd5, 17'b0000000000_0000_000},
      {3'b111, 3'd5, 17'b0000000000_0000_000},
      {3'b111, 3'd5, 17'b0000000000_0000_000}};
    opcode = 11'b00000000000;
    for (int i = 0; i < 5; i++) begin
      {imem_ready, dmem_ready, zero} = v[i][22:20];
      #1;
      if ({state, ctl, illegal} !== {v[i][19:0], (i >= 2) ? 1'b1 : 1'b0}) begin
        errs++; $display("FAIL trap[%0d]: got st=%0d ctl=%b ill=%b, want st=%0d ctl=%b", i, state, ctl, illegal, v[i][19:17], v[i][16:0]);
      end
      vecs++;
      tick();
    end
    if (retired !== exp_ret) begin
      errs++; $display("FAIL trap_retired: got %0d, want %0d", retired, exp_ret);
    end
    vecs++;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_ret = 0;
    #1;
    if ({state, illegal, retired} !== 36'd0) begin
      errs++; $display("FAIL trap_exit: got st=%0d ill=%b ret=%0d, want 0 0 0", state, illegal, retired);
    end
    vecs++;
  endtask
`else
  task automatic test_illegal();
    logic [22:0] v [3] = '{
      {3'b110, 3'd0, 17'b1100000000_0000_000},
      {3'b110, 3'd1, 17'b0000000000_0000_000},
      {3'b110, 3'd4, 17'b0010000000_0000_000}};
    opcode = 11'b00000000000;
    for (int i = 0; i < 3; i++) begin
      {imem_ready, dmem_ready, zero} = v[i][22:20];
      #1;
      if ({state, ctl, illegal} !== {v[i][19:0], 1'b0}) begin
        errs++; $display("FAIL nop[%0d]: got st=%0d ctl=%b ill=%b, want st=%0d ctl=%b ill=0", i, state, ctl, illegal, v[i][19:17], v[i][16:0]);
      end
      vecs++;
      tick();
    end
    exp_ret++;
    if ({state, retired} !== {3'd0, exp_ret[31:0]}) begin
      errs++; $display("FAIL nop_retired: got st=%0d ret=%0d, want st=0 ret=%0d", state, retired, exp_ret);
    end
    vecs++;
  endtask
`endif

  task automatic test_reset_mid();
    logic [22:0] v [4] = '{
      {3'b100, 3'd0, 17'b1100000000_0000_000},
      {3'b100, 3'd1, 17'b0000000000_0000_001},
      {3'b100, 3'd2, 17'b0000010000_0010_001},
      {3'b100, 3'd3, 17'b0000010010_0010_001}};
    opcode = 11'b11111000010;
    for (int i = 0; i < 4; i++) begin
      {imem_ready, dmem_ready, zero} = v[i][22:20];
      #1;
      if ({state, ctl} !== v[i][19:0]) begin
        errs++; $display("FAIL rstmid[%0d]: got st=%0d ctl=%b, want st=%0d ctl=%b", i, state, ctl, v[i][19:17], v[i][16:0]);
      end
      vecs++;
      if (i < 3) tick();
    end
    Reset = 1'b1; dmem_ready = 1'b1;
    #1;
    if ({state, ctl, retired} !== 52'd0) begin
      errs++; $display("FAIL rstmid_hold: got st=%0d ctl=%b ret=%0d, want all 0", state, ctl, retired);
    end
    vecs++;
    tick();
    Reset = 1'b0;
    exp_ret = 0;
    #1;
    if ({state, ctl, retired, illegal} !== {3'd0, 17'b1100000000_0000_000, 32'd0, 1'b0}) begin
      errs++; $display("FAIL rstmid_after: got st=%0d ctl=%b ret=%0d ill=%b, want st=0 ctl=11000000000000000 ret=0 ill=0", state, ctl, retired, illegal);
    end
    vecs++;
  endtask

  initial begin
    Reset = 1'b1; opcode = 11'd0; zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    tick();
    tick();
    test_reset();
    test_addreg();
    test_ldur();
    test_cbz();
    test_stur();
    test_movz();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
